// File: rtl/lut_pkg.sv
// Shared definitions for the colour-correction LUT loader and its consumer.
//   - LUT geometry (payload size) and the default packet header byte, which
//     the LUT consumer's address decode also relies on.
//   - Loader FSM state encoding (plain localparams so legacy tools can use it).
//   - err_code values reported to the control/status logic.
//   - in_packet(): true for the states that sit between header and completion.
package lut_pkg;

  localparam int         LUT_BYTES   = 768;   // 3 channels x 256 entries
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_HDR   = 2'd1;
  localparam logic [1:0] ERR_SHORT = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  // A stop seen in one of these states cuts a packet short.
  function automatic logic in_packet(input logic [2:0] st);
    return (st == ST_HDR) || (st == ST_DATA) || (st == ST_CSUM);
  endfunction

endpackage

// File: rtl/lut_packet_loader.sv
// lut_packet_loader: frames the I2C byte stream into LUT write packets.
//
// Checks the header byte that follows an I2C start, then forwards the next
// LUT_BYTES payload bytes as VLD pulses (1 clk after rx_vld) with SOP on the
// first and EOP on the last, and reports completion/errors.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i2c_start/i2c_stop  one-cycle start (or repeated start) / stop pulses
//   rx_vld, rx_data     one-cycle received-byte strobe and its byte
//   SOP, EOP, VLD       payload framing pulses; SOP/EOP only with VLD
//   packet_data         payload byte, held between VLD pulses
//   load_done/load_err  one-cycle completion / rejection pulses
//   err_code            reason for the most recent error (held)
//   lut_valid           the LUT holds a complete, accepted packet
//
// Build option: define LUT_CHECKSUM_EN to require a trailing checksum byte
// (modulo-256 sum of the header and all payload bytes) before completion.
// Without it, EOP completes the packet and no sum register exists.
//
// Handshake: there is no back-pressure. Every rx_vld byte accepted in DATA
// produces exactly one VLD pulse on the following cycle; the LUT write port
// must take one byte per VLD.
module lut_packet_loader #(
  parameter int         LUT_BYTES   = lut_pkg::LUT_BYTES,
  parameter logic [7:0] HEADER_BYTE = lut_pkg::HEADER_BYTE,
  parameter int         CNT_W       = 10  // 2**CNT_W must be >= LUT_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_start,
  input  logic       i2c_stop,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  output logic       SOP,
  output logic       EOP,
  output logic       VLD,
  output logic [7:0] packet_data,
  output logic       load_done,
  output logic       load_err,
  output logic [1:0] err_code,
  output logic       lut_valid
);
  import lut_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LUT_BYTES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             lut_valid_q, lut_valid_d;
  logic             first_byte, last_byte;
`ifdef LUT_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  assign first_byte = (cnt_q == '0);
  assign last_byte  = (cnt_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    vld_d       = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    lut_valid_d = lut_valid_q;
`ifdef LUT_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    if (i2c_start) begin
      // Start (or repeated start) wins over a same-cycle byte, which is dropped.
      if ((state_q == ST_DATA) || (state_q == ST_CSUM)) begin
        err_d      = 1'b1;
        err_code_d = ERR_SHORT;
      end
      state_d = ST_HDR;
    end else begin
      if (rx_vld) begin
        case (state_q)
          ST_HDR: begin
            if (rx_data == HEADER_BYTE) begin
              state_d = ST_DATA;
              cnt_d   = '0;
`ifdef LUT_CHECKSUM_EN
              sum_d   = HEADER_BYTE;
`endif
            end else begin
              state_d    = ST_DRAIN;
              err_d      = 1'b1;
              err_code_d = ERR_HDR;
            end
          end
          ST_DATA: begin
            data_d = rx_data;
            vld_d  = 1'b1;
            sop_d  = first_byte;
            eop_d  = last_byte;
            cnt_d  = cnt_q + CNT_W'(1);
            // A new packet invalidates the LUT as soon as it starts overwriting.
            if (first_byte) lut_valid_d = 1'b0;
`ifdef LUT_CHECKSUM_EN
            sum_d = sum_q + rx_data;
            if (last_byte) state_d = ST_CSUM;
`else
            if (last_byte) begin
              state_d     = ST_DONE;
              done_d      = 1'b1;
              lut_valid_d = 1'b1;
            end
`endif
          end
`ifdef LUT_CHECKSUM_EN
          ST_CSUM: begin
            if (rx_data == sum_q) begin
              state_d     = ST_DONE;
              done_d      = 1'b1;
              lut_valid_d = 1'b1;
            end else begin
              state_d    = ST_DRAIN;
              err_d      = 1'b1;
              err_code_d = ERR_CSUM;
            end
          end
`endif
          ST_DONE: begin
            // Extra byte after a complete packet: the LUT may be stale.
            state_d     = ST_DRAIN;
            err_d       = 1'b1;
            err_code_d  = ERR_CSUM;
            lut_valid_d = 1'b0;
          end
          default: ;
        endcase
      end

      // Stop applies after any same-cycle byte, so it is judged on state_d.
      if (i2c_stop) begin
        if (in_packet(state_d)) begin
          err_d      = 1'b1;
          err_code_d = ERR_SHORT;
        end
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      vld_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      lut_valid_q <= 1'b0;
`ifdef LUT_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      vld_q       <= vld_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      lut_valid_q <= lut_valid_d;
`ifdef LUT_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign SOP         = sop_q;
  assign EOP         = eop_q;
  assign VLD         = vld_q;
  assign packet_data = data_q;
  assign load_done   = done_q;
  assign load_err    = err_q;
  assign err_code    = err_code_q;
  assign lut_valid   = lut_valid_q;

endmodule

// File: doc/lut_packet_loader.md
Name: lut_packet_loader

Overview:
- Upstream feeder of the colour-correction LUT stage.
- Receives the byte stream from the I2C slave (start/stop conditions plus received bytes), checks the packet header, and frames the 768 LUT payload bytes as SOP/EOP/VLD/packet_data for the LUT write port.
- Reports load completion and errors to the control/status logic.

Parameters:
- LUT_BYTES, 768, payload bytes per packet (3 channels x 256 entries).
- HEADER_BYTE, 8'hA5, required first byte after an I2C start.
- CNT_W, 10, payload counter width; must satisfy 2^CNT_W >= LUT_BYTES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i2c_start  in  1  one-cycle pulse: I2C start or repeated-start detected.
- i2c_stop  in  1  one-cycle pulse: I2C stop detected.
- rx_vld  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- SOP  out  1  first payload byte; asserted only together with VLD.
- EOP  out  1  last payload byte (index LUT_BYTES-1); asserted only together with VLD.
- VLD  out  1  packet_data holds a valid payload byte.
- packet_data  out  8  payload byte.
- load_done  out  1  one-cycle pulse: packet accepted.
- load_err  out  1  one-cycle pulse: packet rejected or aborted.
- err_code  out  2  reason for the last error, held until the next error: 0 none, 1 bad header, 2 short packet/abort, 3 checksum or overrun.
- lut_valid  out  1  level: the LUT holds a complete, accepted packet.

Behaviour:
- Reset: all outputs are 0, err_code is 0, state is IDLE, counter is 0. Reset mid-packet drops the packet without asserting load_err.
- FSM states: IDLE, HDR, DATA, CSUM, DONE, DRAIN.
- IDLE:
  - i2c_start -> HDR.
  - rx_vld is ignored.
- HDR, on rx_vld:
  - rx_data == HEADER_BYTE -> DATA; counter cleared.
  - Otherwise -> DRAIN; load_err pulses; err_code = 1.
- DATA, on rx_vld:
  - Register the byte to packet_data and assert VLD on the next cycle. Latency is exactly 1 clk from rx_vld to VLD.
  - SOP = (counter == 0). On SOP, lut_valid clears.
  - EOP = (counter == LUT_BYTES-1). The EOP byte moves the FSM to CSUM (CHECKSUM_EN) or DONE.
  - counter increments on every byte.
- DONE:
  - load_done pulses once, on entry.
  - lut_valid sets on entry.
  - An rx_vld in DONE -> overrun: load_err pulses; err_code = 3; lut_valid clears; -> DRAIN.
- DRAIN: ignore bytes until i2c_stop.
- i2c_stop in any state -> IDLE.
  - Stop while in HDR, DATA or CSUM -> load_err pulses; err_code = 2.
  - Stop in IDLE, DONE or DRAIN -> no error.
- i2c_start outside IDLE (repeated start) -> HDR.
  - If the FSM was in DATA or CSUM, load_err pulses and err_code = 2.
  - Bytes already written to the LUT are not retracted; lut_valid stays 0.
- Simultaneous events:
  - rx_vld with i2c_stop in the same cycle: the byte is processed first, then the stop applies. An EOP byte plus stop completes the packet only when CHECKSUM_EN is off.
  - i2c_start with rx_vld in the same cycle: start wins and the byte is discarded.
- Between pulses, SOP, EOP and VLD are 0. packet_data holds its last value.

Optional Feature:
- Macro: LUT_CHECKSUM_EN.
- Defined:
  - After EOP the FSM enters CSUM.
  - The next byte is compared to the 8-bit modulo-256 sum of HEADER_BYTE and all payload bytes.
  - Match -> DONE.
  - Mismatch -> DRAIN; load_err pulses; err_code = 3; lut_valid stays 0.
- Undefined:
  - EOP goes directly to DONE.
  - No sum register or CSUM state is synthesised.

Decomposition:
- Shared package (lut_pkg):
  - FSM state encoding.
  - err_code constants ERR_NONE, ERR_HDR, ERR_SHORT, ERR_CSUM.
  - LUT_BYTES and the default HEADER_BYTE, shared with the LUT consumer's address decode.
- No sub-module. The checksum accumulator stays inline under the macro.

Test Plan:
- Good packet: start, header 8'hA5, bytes 0..767 (data = index mod 256), stop -> 768 VLD pulses; SOP with data 0x00; EOP with data 0xFF on the 768th; one load_done; lut_valid = 1; err_code = 0.
- Bad header: start, 8'h5A, 10 bytes, stop -> no VLD; load_err once; err_code = 1.
- Short packet: start, header, 300 bytes, stop -> 300 VLD with one SOP and no EOP; load_err; err_code = 2; lut_valid = 0.
- Repeated start at byte 100, then a full good packet -> err_code = 2 pulse first, then load_done; exactly two SOP pulses in total.
- Overrun (macro off): header, 769 bytes -> EOP on byte 768; load_done; then load_err with err_code = 3; lut_valid = 0.
- LUT_CHECKSUM_EN: payload of all 8'h01, checksum 8'hA5 (0xA5 + 768 mod 256) -> load_done. Checksum 8'hA6 -> load_err; err_code = 3.
